stream_credit_rx: RTL

- Receiver end of the credit-based stream link between join stages.
- The sender holds an up/down credit counter; this block buffers incoming beats in a C_DEPTH-entry FIFO and drains them downstream with valid/ready.
- It returns freed slots to the sender as batched credit messages.
- After reset it advertises the full initial credit (C_DEPTH).

---
 rtl/stream_credit_rx_pkg.sv | 14 +
 rtl/stream_credit_rx_fifo.sv | 57 +++++
 rtl/stream_credit_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/stream_credit_rx_pkg.sv
// Shared types and helpers for the credit-based stream receiver.
package stream_credit_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_RET  = 2'd2
    } state_t;

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_credit_rx_fifo.sv
// First-word fall-through FIFO: registered storage, wrapping pointers, fill count.
module stream_credit_rx_fifo #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_DEPTH      = 16,
    parameter int CW           = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    input  logic                    pop,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]           occupancy,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(C_DEPTH);

    logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    push_ok;
    logic                    pop_ok;

    assign full      = (count == CW'(C_DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign rd_data   = mem[rd_ptr];
    assign occupancy = count;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/stream_credit_rx.sv
// Credit-based stream receiver: buffers beats and returns freed slots as batched credits.
module stream_credit_rx
    import stream_credit_pkg::*;
#(
    parameter int  C_DATA_WIDTH = 64,
    parameter int  C_DEPTH      = 16,
    parameter int  C_BATCH      = 4,
    parameter int  C_TIMEOUT    = 8,
    localparam int CW           = credit_w(C_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [C_DATA_WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [C_DATA_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    cr_valid,
    output logic [CW-1:0]           cr_count,
    input  logic                    cr_ack,
    output logic [CW-1:0]           occupancy,
    output logic                    overflow_err
);

    localparam int TW = $clog2(C_TIMEOUT + 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] pending_r;
    logic [CW-1:0] cr_count_r;
    logic [TW-1:0] idle_cnt;
    logic          overflow_r;
    logic          launch;
    logic          ret_ack;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_occ;

    stream_credit_rx_fifo #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_DEPTH      (C_DEPTH),
        .CW           (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .wr_data   (in_data),
        .pop       (pop),
        .rd_data   (out_data),
        .occupancy (fifo_occ),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid    = !empty && !rst;
    assign pop          = out_valid && out_ready;
    assign occupancy    = rst ? '0 : fifo_occ;
    assign overflow_err = overflow_r && !rst;
    // The initial grant is not drawn from pending_r; only an acked return is.
    assign ret_ack      = (state_q == S_RET) && cr_ack;

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        cr_valid = 1'b0;
        cr_count = cr_count_r;
        case (state_q)
            S_INIT: begin
                cr_valid = !rst;
                cr_count = CW'(C_DEPTH);
                if (cr_ack) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if ((pending_r >= CW'(C_BATCH)) ||
                    ((pending_r != '0) && (idle_cnt == TW'(C_TIMEOUT)))) begin
                    launch  = 1'b1;
                    state_d = S_RET;
                end
            end
            S_RET: begin
                cr_valid = !rst;
                if (cr_ack) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            pending_r  <= '0;
            cr_count_r <= '0;
            idle_cnt   <= '0;
            overflow_r <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                cr_count_r <= pending_r;
            end
            pending_r <= pending_r + CW'(pop) - (ret_ack ? cr_count_r : CW'(0));
            if (pop || (pending_r == '0) || (state_q != S_RUN)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TW'(C_TIMEOUT)) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
            if (in_valid && full) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule
